// File: rtl/wb_stage_seq.sv
// Registered write-back stage: scalar RF write, vector result serialisation into beats,
// branch resolution. Optional branch counters enabled by defining WB_BRANCH_STATS_EN.
module wb_stage_seq #(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned VWIDTH = 1048,
  parameter  int unsigned BEAT   = 256,
  parameter  int unsigned VADDRW = 4,
  localparam int unsigned BEATS  = (VWIDTH + BEAT - 1) / BEAT,
  localparam int unsigned BCW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [4:0]        m_rd,
  input  logic [WIDTH-1:0]  m_aluresult,
  input  logic [WIDTH-1:0]  m_dmemdata,
  input  logic [WIDTH-1:0]  m_csrrdata,
  input  logic [WIDTH-1:0]  m_pc,
  input  logic [WIDTH-1:0]  m_branchimm,
  input  logic [VWIDTH-1:0] m_vresult,
  input  logic [VWIDTH-1:0] m_vdmemdata,
  input  logic [1:0]        m_mem2reg,
  input  logic [1:0]        m_pcsource,
  input  logic [1:0]        m_branchcntl,
  input  logic [1:0]        m_bpflag,
  input  logic              m_regwrite,
  input  logic              m_zero,
  input  logic              m_flag512,
  output logic [4:0]        regaddr,
  output logic [WIDTH-1:0]  regwd,
  output logic              regwe,
  output logic [VADDRW-1:0] vaddr,
  output logic [BCW-1:0]    vbeat,
  output logic [BEAT-1:0]   vwd,
  output logic              vwe,
  output logic              vlast,
  output logic [WIDTH-1:0]  dnextpc,
  output logic              branchpcwe,
  output logic [1:0]        branchpdres,
  output logic [31:0]       br_total,
  output logic [31:0]       br_redirect
);

  localparam int unsigned PADW = BEATS * BEAT;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]      r_state;
  logic [BCW-1:0]  r_bcnt;
  logic [PADW-1:0] r_vbuf;

  logic             w_accept;
  logic [PADW-1:0]  w_vsrc;
  logic [WIDTH-1:0] w_regwd;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_btgt;
  logic [WIDTH-1:0] w_dnext;
  logic             w_bpcwe;
  logic [1:0]       w_pdres;

  assign m_ready  = (r_state == S_IDLE);
  assign w_accept = m_valid & m_ready;
  assign w_pc4    = m_pc + WIDTH'(4);

  always_comb begin
    w_regwd = m_aluresult;
    unique case (m_mem2reg)
      2'b00: w_regwd = m_aluresult;
      2'b01: w_regwd = m_dmemdata;
      2'b10: w_regwd = w_pc4;
      2'b11: w_regwd = m_csrrdata;
      default: w_regwd = m_aluresult;
    endcase
  end

  // Source is zero-extended to a whole number of beats so the last beat is padded.
  always_comb begin
    w_vsrc = '0;
    unique case (m_mem2reg)
      2'b00: w_vsrc[VWIDTH-1:0] = m_vresult;
      2'b01: w_vsrc[VWIDTH-1:0] = m_vdmemdata;
      2'b10: w_vsrc[VWIDTH-1:0] = '0;
      2'b11: w_vsrc[VWIDTH-1:0] = '1;
      default: w_vsrc = '0;
    endcase
  end

  // Branch target is the resolved next PC; the predictor flag only decides redirect.
  always_comb begin
    w_btgt  = m_zero ? (w_pc4 + m_branchimm) : w_pc4;
    w_bpcwe = 1'b0;
    w_pdres = 2'b00;
    unique case (m_branchcntl)
      2'b01: begin
        w_pdres = m_zero ? 2'b10 : 2'b01;
        w_bpcwe = m_bpflag[1] ? ~m_zero : m_zero;
      end
      2'b10: begin
        w_pdres = 2'b00;
        w_bpcwe = 1'b1;
      end
      default: begin
        w_pdres = 2'b00;
        w_bpcwe = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_dnext = '0;
    unique case (m_pcsource)
      2'b00: w_dnext = '0;
      2'b01: w_dnext = w_btgt;
      2'b10: w_dnext = m_aluresult;
      2'b11: w_dnext = '0;
      default: w_dnext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bcnt      <= '0;
      r_vbuf      <= '0;
      regaddr     <= '0;
      regwd       <= '0;
      regwe       <= 1'b0;
      vaddr       <= '0;
      vbeat       <= '0;
      vwd         <= '0;
      vwe         <= 1'b0;
      vlast       <= 1'b0;
      dnextpc     <= '0;
      branchpcwe  <= 1'b0;
      branchpdres <= '0;
    end else begin
      regwe      <= 1'b0;
      vwe        <= 1'b0;
      vlast      <= 1'b0;
      branchpcwe <= 1'b0;
      if (r_state == S_BURST) begin
        vwe   <= 1'b1;
        vbeat <= r_bcnt;
        vwd   <= r_vbuf[32'(r_bcnt) * BEAT +: BEAT];
        if (r_bcnt == BCW'(BEATS - 1)) begin
          vlast   <= 1'b1;
          r_state <= S_IDLE;
          r_bcnt  <= '0;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end else if (w_accept) begin
        branchpcwe  <= w_bpcwe;
        branchpdres <= w_pdres;
        dnextpc     <= w_dnext;
        if (!m_flag512) begin
          regwe   <= m_regwrite & (m_rd != 5'd0);
          regaddr <= m_rd;
          regwd   <= w_regwd;
        end else if (m_regwrite) begin
          // Beat 0 leaves on the accept edge; the buffer feeds the remaining beats.
          r_vbuf <= w_vsrc;
          vaddr  <= m_rd[VADDRW-1:0];
          vwe    <= 1'b1;
          vbeat  <= '0;
          vwd    <= w_vsrc[BEAT-1:0];
          if (BEATS == 1) begin
            vlast <= 1'b1;
          end else begin
            r_state <= S_BURST;
            r_bcnt  <= BCW'(1);
          end
        end
      end
    end
  end

`ifdef WB_BRANCH_STATS_EN
  logic [31:0] r_br_total;
  logic [31:0] r_br_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_total    <= '0;
      r_br_redirect <= '0;
    end else begin
      if (w_accept && (m_branchcntl == 2'b01)) begin
        r_br_total <= r_br_total + 32'd1;
      end
      if (w_accept && w_bpcwe) begin
        r_br_redirect <= r_br_redirect + 32'd1;
      end
    end
  end

  assign br_total    = r_br_total;
  assign br_redirect = r_br_redirect;
`else
  assign br_total    = '0;
  assign br_redirect = '0;
`endif

endmodule
